// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ctrl
// Purpose  : UART receive-side controller: baud/enable control with guarded
//            reconfiguration, event detection, FWFT byte FIFO, error counters.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_ctrl #(
    parameter int FIFO_DEPTH   = 4,
    parameter int GUARD_CYCLES = 16,
    parameter int ERR_LIMIT    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_wr,
    input  logic [2:0] cfg_baud,
    input  logic       cfg_enable,
    input  logic       clear,
    output logic [2:0] baud_select,
    output logic       Rx_EN,
    input  logic [7:0] Rx_DATA,
    input  logic       Rx_VALID,
    input  logic       Rx_PERROR,
    input  logic       Rx_FERROR,
    input  logic       rd_req,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic [4:0] fifo_count,
    output logic       overrun,
    output logic [7:0] perr_count,
    output logic [7:0] ferr_count,
    output logic       locked_out
);
    localparam int c_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_GW = $clog2(GUARD_CYCLES + 1);
    localparam int c_CW = $clog2(ERR_LIMIT + 1);

    localparam logic [1:0] c_DISABLED = 2'd0;
    localparam logic [1:0] c_RUN      = 2'd1;
    localparam logic [1:0] c_RECONFIG = 2'd2;
    localparam logic [1:0] c_LOCKOUT  = 2'd3;

    localparam logic [c_GW-1:0] c_GUARD_LAST = c_GW'(GUARD_CYCLES - 1);
    localparam logic [c_CW-1:0] c_ERR_LAST   = c_CW'(ERR_LIMIT - 1);
    localparam logic [4:0]      c_DEPTH      = 5'(FIFO_DEPTH);

    logic [1:0]      state_q, state_d;
    logic [2:0]      baud_q, baud_d;
    logic [2:0]      pend_baud_q, pend_baud_d;
    logic            pend_en_q, pend_en_d;
    logic [c_GW-1:0] guard_q, guard_d;
    logic [c_CW-1:0] cerr_q, cerr_d;
    logic [7:0]      perr_cnt_q, perr_cnt_d;
    logic [7:0]      ferr_cnt_q, ferr_cnt_d;
    logic            overrun_q, overrun_d;
    logic            valid_prev_q, perr_prev_q, ferr_prev_q;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [c_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [4:0]      count_q, count_d;

    logic w_run, w_v_edge, w_p_edge, w_f_edge;
    logic w_err_frame, w_good_frame, w_full, w_pop, w_push;

    assign w_run    = (state_q == c_RUN);
    assign w_v_edge = Rx_VALID  & ~valid_prev_q;
    assign w_p_edge = Rx_PERROR & ~perr_prev_q;
    assign w_f_edge = Rx_FERROR & ~ferr_prev_q;

    // A valid edge while an error level is high counts as an errored frame.
    assign w_err_frame  = w_run & (w_p_edge | w_f_edge | (w_v_edge & (Rx_PERROR | Rx_FERROR)));
    assign w_good_frame = w_run & w_v_edge & ~Rx_PERROR & ~Rx_FERROR;

    assign w_full = (count_q == c_DEPTH);
    assign w_pop  = rd_req & (count_q != 5'd0);
    assign w_push = w_good_frame & (~w_full | w_pop);

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        pend_baud_d = pend_baud_q;
        pend_en_d   = pend_en_q;
        guard_d     = guard_q;
        cerr_d      = cerr_q;
        perr_cnt_d  = perr_cnt_q;
        ferr_cnt_d  = ferr_cnt_q;
        overrun_d   = overrun_q;
        count_d     = count_q;

        if (w_push && !w_pop) begin
            count_d = count_q + 5'd1;
        end else if (!w_push && w_pop) begin
            count_d = count_q - 5'd1;
        end
        if (w_good_frame && w_full && !w_pop) begin
            overrun_d = 1'b1;
        end

        if (w_err_frame) begin
            if (Rx_PERROR && (perr_cnt_q != 8'hFF)) perr_cnt_d = perr_cnt_q + 8'd1;
            if (Rx_FERROR && (ferr_cnt_q != 8'hFF)) ferr_cnt_d = ferr_cnt_q + 8'd1;
            cerr_d = cerr_q + c_CW'(1);
            if (cerr_q >= c_ERR_LAST) state_d = c_LOCKOUT;
        end
        if (w_good_frame) begin
            cerr_d = '0;
        end

        if ((state_q == c_RECONFIG) && !cfg_wr) begin
            if (guard_q == c_GUARD_LAST) begin
                baud_d  = pend_baud_q;
                state_d = pend_en_q ? c_RUN : c_DISABLED;
            end else begin
                guard_d = guard_q + c_GW'(1);
            end
        end

        if (clear) begin
            perr_cnt_d = 8'd0;
            ferr_cnt_d = 8'd0;
            overrun_d  = 1'b0;
            cerr_d     = '0;
            if (state_q == c_LOCKOUT) state_d = c_DISABLED;
        end

        if (cfg_wr) begin
            case (state_q)
                c_RUN: begin
                    if (!cfg_enable) begin
                        baud_d  = cfg_baud;
                        state_d = c_DISABLED;
                    end else if (cfg_baud != baud_q) begin
                        pend_baud_d = cfg_baud;
                        pend_en_d   = 1'b1;
                        guard_d     = '0;
                        state_d     = c_RECONFIG;
                    end
                end
                c_RECONFIG: begin
                    pend_baud_d = cfg_baud;
                    pend_en_d   = cfg_enable;
                    guard_d     = '0;
                end
                default: begin
                    baud_d  = cfg_baud;
                    cerr_d  = '0;
                    state_d = cfg_enable ? c_RUN : c_DISABLED;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= c_DISABLED;
            baud_q       <= 3'd0;
            pend_baud_q  <= 3'd0;
            pend_en_q    <= 1'b0;
            guard_q      <= '0;
            cerr_q       <= '0;
            perr_cnt_q   <= 8'd0;
            ferr_cnt_q   <= 8'd0;
            overrun_q    <= 1'b0;
            valid_prev_q <= 1'b0;
            perr_prev_q  <= 1'b0;
            ferr_prev_q  <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= 5'd0;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            pend_baud_q  <= pend_baud_d;
            pend_en_q    <= pend_en_d;
            guard_q      <= guard_d;
            cerr_q       <= cerr_d;
            perr_cnt_q   <= perr_cnt_d;
            ferr_cnt_q   <= ferr_cnt_d;
            overrun_q    <= overrun_d;
            valid_prev_q <= Rx_VALID;
            perr_prev_q  <= Rx_PERROR;
            ferr_prev_q  <= Rx_FERROR;
            count_q      <= count_d;
            if (w_push) wr_ptr_q <= wr_ptr_q + c_AW'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + c_AW'(1);
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= Rx_DATA;
    end

    assign baud_select = baud_q;
    assign Rx_EN       = (state_q == c_RUN);
    assign locked_out  = (state_q == c_LOCKOUT);
    assign rd_valid    = (count_q != 5'd0);
    assign rd_data     = (count_q != 5'd0) ? mem_q[rd_ptr_q] : 8'h00;
    assign fifo_count  = count_q;
    assign overrun     = overrun_q;
    assign perr_count  = perr_cnt_q;
    assign ferr_count  = ferr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_ctrl
// Purpose  : Self-checking bench for uart_rx_ctrl against a queue-based model.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_ctrl;
    localparam int c_DEPTH = 4;
    localparam int c_GUARD = 16;
    localparam int c_ELIM  = 3;
    localparam int c_DIS = 0, c_RUN = 1, c_RCF = 2, c_LCK = 3;

    logic       clk = 1'b0, reset = 1'b0, cfg_wr = 1'b0, cfg_enable = 1'b0, clear = 1'b0;
    logic       Rx_VALID = 1'b0, Rx_PERROR = 1'b0, Rx_FERROR = 1'b0, rd_req = 1'b0;
    logic [2:0] cfg_baud = 3'd0;
    logic [7:0] Rx_DATA = 8'd0;
    logic [2:0] baud_select;
    logic       Rx_EN, rd_valid, overrun, locked_out;
    logic [7:0] rd_data, perr_count, ferr_count;
    logic [4:0] fifo_count;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.FIFO_DEPTH(c_DEPTH), .GUARD_CYCLES(c_GUARD), .ERR_LIMIT(c_ELIM)) u_dut (
        .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_baud(cfg_baud),
        .cfg_enable(cfg_enable), .clear(clear), .baud_select(baud_select), .Rx_EN(Rx_EN),
        .Rx_DATA(Rx_DATA), .Rx_VALID(Rx_VALID), .Rx_PERROR(Rx_PERROR), .Rx_FERROR(Rx_FERROR),
        .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid), .fifo_count(fifo_count),
        .overrun(overrun), .perr_count(perr_count), .ferr_count(ferr_count),
        .locked_out(locked_out)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode number, byte queue, guard countdown.
    int         m_mode = c_DIS, m_baud = 0, m_pbaud = 0, m_left = 0, m_consec = 0;
    int         m_perr = 0, m_ferr = 0;
    bit         m_pen = 0, m_ovr = 0, m_pv = 0, m_pp = 0, m_pf = 0;
    logic [7:0] m_q[$];
    bit         chk_en = 0;

    always @(posedge clk) begin : model
        int old;
        bit ev_v, ev_p, ev_f, err, good, pop;
        if (!reset) begin
            m_mode = c_DIS; m_baud = 0; m_pbaud = 0; m_pen = 0; m_left = 0;
            m_consec = 0; m_perr = 0; m_ferr = 0; m_ovr = 0;
            m_q.delete();
            m_pv = 0; m_pp = 0; m_pf = 0;
        end else begin
            old  = m_mode;
            ev_v = Rx_VALID && !m_pv;
            ev_p = Rx_PERROR && !m_pp;
            ev_f = Rx_FERROR && !m_pf;
            err  = (old == c_RUN) && (ev_p || ev_f || (ev_v && (Rx_PERROR || Rx_FERROR)));
            good = (old == c_RUN) && ev_v && !Rx_PERROR && !Rx_FERROR;
            pop  = rd_req && (m_q.size() > 0);
            if (pop) void'(m_q.pop_front());
            if (good) begin
                if (m_q.size() < c_DEPTH) m_q.push_back(Rx_DATA);
                else m_ovr = 1;
                m_consec = 0;
            end
            if (err) begin
                if (Rx_PERROR) m_perr = (m_perr >= 255) ? 255 : m_perr + 1;
                if (Rx_FERROR) m_ferr = (m_ferr >= 255) ? 255 : m_ferr + 1;
                m_consec++;
                if (m_consec >= c_ELIM) m_mode = c_LCK;
            end
            if (old == c_RCF && !cfg_wr) begin
                m_left--;
                if (m_left == 0) begin
                    m_baud = m_pbaud;
                    m_mode = m_pen ? c_RUN : c_DIS;
                end
            end
            if (clear) begin
                m_perr = 0; m_ferr = 0; m_ovr = 0; m_consec = 0;
                if (old == c_LCK) m_mode = c_DIS;
            end
            if (cfg_wr) begin
                if (old == c_DIS || old == c_LCK) begin
                    m_baud = int'(cfg_baud); m_consec = 0;
                    m_mode = cfg_enable ? c_RUN : c_DIS;
                end else if (old == c_RUN) begin
                    if (!cfg_enable) begin
                        m_baud = int'(cfg_baud); m_mode = c_DIS;
                    end else if (int'(cfg_baud) != m_baud) begin
                        m_pbaud = int'(cfg_baud); m_pen = 1; m_left = c_GUARD; m_mode = c_RCF;
                    end
                end else begin
                    m_pbaud = int'(cfg_baud); m_pen = cfg_enable; m_left = c_GUARD;
                end
            end
            m_pv = Rx_VALID; m_pp = Rx_PERROR; m_pf = Rx_FERROR;
        end
    end

    always @(negedge clk) begin : compare
        if (chk_en) begin
            check("baud_select", int'(baud_select), m_baud);
            check("Rx_EN", int'(Rx_EN), (m_mode == c_RUN) ? 1 : 0);
            check("locked_out", int'(locked_out), (m_mode == c_LCK) ? 1 : 0);
            check("rd_valid", int'(rd_valid), (m_q.size() > 0) ? 1 : 0);
            check("fifo_count", int'(fifo_count), m_q.size());
            check("overrun", int'(overrun), int'(m_ovr));
            check("perr_count", int'(perr_count), m_perr);
            check("ferr_count", int'(ferr_count), m_ferr);
            if (m_q.size() > 0) check("rd_data", int'(rd_data), int'(m_q[0]));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic good_pulse(input logic [7:0] d);
        Rx_DATA = d; Rx_VALID = 1'b1; cyc(1); Rx_VALID = 1'b0; cyc(1);
    endtask

    task automatic perr_pulse();
        Rx_PERROR = 1'b1; cyc(1); Rx_PERROR = 1'b0; cyc(1);
    endtask

    task automatic ferr_pulse();
        Rx_FERROR = 1'b1; cyc(1); Rx_FERROR = 1'b0; cyc(1);
    endtask

    task automatic cfg(input logic [2:0] b, input logic e);
        cfg_baud = b; cfg_enable = e; cfg_wr = 1'b1; cyc(1); cfg_wr = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int low;
        int k;
        logic [7:0] exp4 [4];
        reset = 1'b0;
        cyc(1);
        chk_en = 1;
        cyc(2);
        check("rst_Rx_EN", int'(Rx_EN), 0);
        check("rst_baud", int'(baud_select), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_rd_data", int'(rd_data), 0);
        reset = 1'b1;
        cyc(1);

        // Long VALID level yields exactly one byte.
        cfg(3'd3, 1'b1);
        check("t1_Rx_EN", int'(Rx_EN), 1);
        Rx_DATA = 8'hA5; Rx_VALID = 1'b1; cyc(50); Rx_VALID = 1'b0; cyc(1);
        check("t1_count", int'(fifo_count), 1);
        check("t1_rd_data", int'(rd_data), 'hA5);
        rd_req = 1'b1; cyc(1); rd_req = 1'b0;
        check("t1_rd_valid", int'(rd_valid), 0);

        // Overflow, then simultaneous push and pop when full.
        for (int i = 1; i <= 5; i++) good_pulse(8'(i));
        check("t2_count", int'(fifo_count), 4);
        check("t2_overrun", int'(overrun), 1);
        for (int i = 1; i <= 4; i++) begin
            check("t2_rd_data", int'(rd_data), i);
            rd_req = 1'b1; cyc(1);
        end
        rd_req = 1'b0;
        check("t2_empty", int'(rd_valid), 0);
        for (int i = 0; i < 4; i++) good_pulse(8'(8'h10 + i));
        Rx_DATA = 8'h20; Rx_VALID = 1'b1; rd_req = 1'b1; cyc(1);
        Rx_VALID = 1'b0; rd_req = 1'b0; cyc(1);
        check("t2_pp_count", int'(fifo_count), 4);
        exp4[0] = 8'h11; exp4[1] = 8'h12; exp4[2] = 8'h13; exp4[3] = 8'h20;
        for (int i = 0; i < 4; i++) begin
            check("t2_pp_order", int'(rd_data), int'(exp4[i]));
            rd_req = 1'b1; cyc(1);
        end
        rd_req = 1'b0;

        // Guarded baud change; an edge inside the guard is ignored.
        cfg(3'd5, 1'b1);
        low = 0;
        while (Rx_EN == 1'b0 && low < 100) begin
            low++;
            if (low == 3) begin Rx_DATA = 8'h77; Rx_VALID = 1'b1; end
            if (low == 4) Rx_VALID = 1'b0;
            cyc(1);
        end
        check("t3_guard_len", low, 16);
        check("t3_baud", int'(baud_select), 5);
        check("t3_count", int'(fifo_count), 0);

        // Lockout after three parity errors, then recovery.
        for (int i = 0; i < 3; i++) perr_pulse();
        check("t4_perr", int'(perr_count), 3);
        check("t4_locked", int'(locked_out), 1);
        check("t4_Rx_EN", int'(Rx_EN), 0);
        clear = 1'b1; cyc(1); clear = 1'b0;
        check("t4_clr_perr", int'(perr_count), 0);
        check("t4_clr_locked", int'(locked_out), 0);
        check("t4_clr_overrun", int'(overrun), 0);
        check("t4_clr_Rx_EN", int'(Rx_EN), 0);
        cfg(3'd5, 1'b1);
        check("t4_run", int'(Rx_EN), 1);

        // Interleaved good frames prevent lockout; counter saturates.
        ferr_pulse(); good_pulse(8'h31); ferr_pulse(); ferr_pulse();
        check("t5_ferr", int'(ferr_count), 3);
        check("t5_locked", int'(locked_out), 0);
        rd_req = 1'b1;
        for (int i = 0; i < 130; i++) begin
            good_pulse(8'(i)); ferr_pulse(); ferr_pulse();
        end
        check("t5_sat", int'(ferr_count), 255);
        check("t5_sat_locked", int'(locked_out), 0);

        // Reset in the middle of a reconfiguration with two bytes queued.
        k = 0;
        while (rd_valid && k < 20) begin k++; cyc(1); end
        check("t6_drained", int'(rd_valid), 0);
        rd_req = 1'b0;
        good_pulse(8'h41); good_pulse(8'h42);
        check("t6_count2", int'(fifo_count), 2);
        cfg(3'd6, 1'b1);
        cyc(4);
        reset = 1'b0; cyc(1);
        check("t6_count", int'(fifo_count), 0);
        check("t6_rd_valid", int'(rd_valid), 0);
        check("t6_Rx_EN", int'(Rx_EN), 0);
        check("t6_baud", int'(baud_select), 0);
        check("t6_ferr", int'(ferr_count), 0);
        reset = 1'b1;
        cfg(3'd3, 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cfg_wr = 1'b0; clear = 1'b0;
            rd_req  = ($urandom_range(0, 3) == 0);
            Rx_DATA = 8'($urandom);
            if (m_mode == c_RUN && $urandom_range(0, 59) == 0) begin
                cfg_baud = 3'($urandom_range(0, 7)); cfg_enable = ($urandom_range(0, 4) != 0);
                cfg_wr = 1'b1;
            end else begin
                if ($urandom_range(0, 5) == 0)  Rx_VALID  = ~Rx_VALID;
                if ($urandom_range(0, 24) == 0) Rx_PERROR = ~Rx_PERROR;
                if ($urandom_range(0, 24) == 0) Rx_FERROR = ~Rx_FERROR;
                if (m_mode != c_RUN && $urandom_range(0, 9) == 0) clear = 1'b1;
                if (m_mode != c_RUN && $urandom_range(0, 7) == 0) begin
                    cfg_baud = 3'($urandom_range(0, 7)); cfg_enable = ($urandom_range(0, 4) != 0);
                    cfg_wr = 1'b1;
                end
            end
            cyc(1);
        end
        cfg_wr = 1'b0; clear = 1'b0; rd_req = 1'b0;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART receiver. It configures the receiver's `baud_select` and gates `Rx_EN`, with a guarded reconfiguration sequence for baud changes. It edge-detects the receiver's level-held `Rx_VALID`, `Rx_PERROR` and `Rx_FERROR` outputs, buffers good bytes in a small first-word-fall-through FIFO for the host, and counts errors. It disables the receiver after a run of consecutive errored frames.

## Interface
- `FIFO_DEPTH`, default 4: FIFO entries; power of two, 2..16.
- `GUARD_CYCLES`, default 16: clk cycles `Rx_EN` is held low before a new baud is applied; must be ≥1.
- `ERR_LIMIT`, default 3: consecutive errored frames that trigger lockout; must be ≥1.
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-low reset.
- `cfg_wr`  in  1  one-cycle configuration write strobe.
- `cfg_baud`  in  3  requested baud_select, sampled on `cfg_wr`.
- `cfg_enable`  in  1  requested receiver enable, sampled on `cfg_wr`.
- `clear`  in  1  clears counters, `overrun` and lockout.
- `baud_select`  out  3  to the receiver.
- `Rx_EN`  out  1  to the receiver.
- `Rx_DATA`  in  8  from the receiver.
- `Rx_VALID`, `Rx_PERROR`, `Rx_FERROR`  in  1 each  from the receiver; level signals that may stay high for many cycles.
- `rd_req`  in  1  pop the FIFO head.
- `rd_data`  out  8  FIFO head; meaningful only while `rd_valid` is high.
- `rd_valid`  out  1  FIFO not empty.
- `fifo_count`  out  5  number of occupied entries.
- `overrun`  out  1  sticky; set when a good byte is dropped because the FIFO is full.
- `perr_count`, `ferr_count`  out  8 each  saturating error counters.
- `locked_out`  out  1  high while in LOCKOUT.

## Operation
- States are DISABLED, RUN, RECONFIG and LOCKOUT. `Rx_EN` is 1 only in RUN.
- Reset values: state DISABLED, `baud_select`=0, `Rx_EN`=0, FIFO empty, `rd_valid`=0, `fifo_count`=0, `rd_data`=0, `overrun`=0, both counters 0, `locked_out`=0, consecutive-error count 0, edge registers 0.
- `cfg_wr` in DISABLED or LOCKOUT:
  - Load `baud_select` from `cfg_baud`.
  - Clear the consecutive-error count.
  - Go to RUN if `cfg_enable`=1, otherwise go to DISABLED.
- `cfg_wr` in RUN:
  - `cfg_enable`=0: load the baud and go to DISABLED.
  - `cfg_enable`=1 and `cfg_baud` equals the current `baud_select`: no change.
  - Otherwise: latch the pending baud and enable, then go to RECONFIG.
- RECONFIG:
  - Counts `GUARD_CYCLES`, then loads `baud_select` from the pending value.
  - Then goes to RUN if the pending enable is 1, otherwise to DISABLED.
  - A `cfg_wr` during RECONFIG overwrites the pending values and restarts the guard count.
- Edge detection: each input is registered every cycle in every state. An event is a rising edge, i.e. the input is 1 this cycle and 0 in the previous cycle.
- Events are acted on only in RUN:
  - Error edge (`Rx_PERROR` or `Rx_FERROR` rising), or a `Rx_VALID` edge while either error input is high: the frame is errored.
    - Increment each flagged counter, saturating at 255.
    - Increment the consecutive-error count.
    - Push nothing.
  - `Rx_VALID` edge with both error inputs low: good frame.
    - Push `Rx_DATA` into the FIFO.
    - Clear the consecutive-error count.
  - When the consecutive-error count reaches `ERR_LIMIT`, go to LOCKOUT. In LOCKOUT `Rx_EN`=0 and `locked_out`=1.
- FIFO rules:
  - Push while full with no pop: the byte is dropped and `overrun` is set.
  - Push and pop in the same cycle: both succeed and the count is unchanged, including when full or when holding one entry.
  - Pop while empty: ignored.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
- `clear`:
  - Zeroes both counters, `overrun` and the consecutive-error count.
  - In LOCKOUT it moves the state to DISABLED.
  - If `cfg_wr` is asserted in the same cycle, `clear` applies and `cfg_wr` then decides the next state.
  - The FIFO contents are kept.
- FIFO contents are preserved across all state changes. Only reset empties the FIFO.

## Timing
- Rising edge on `Rx_VALID` at cycle N (input 0 at N-1, 1 at N): entry written at the end of N; `rd_valid` and `fifo_count` updated at N+1.
- `rd_req` at cycle M with `rd_valid`=1: the next entry, or `rd_valid`=0, appears at M+1.
- `rd_data` is a registered head; there is no read latency beyond FWFT.
- `cfg_wr` at cycle C in RUN with a new baud: `Rx_EN`=0 from C+1; new `baud_select` and `Rx_EN`=1 at C+1+`GUARD_CYCLES`.
- `cfg_wr` at C in DISABLED: `baud_select` and `Rx_EN` updated at C+1.
- The `ERR_LIMIT`-th error edge at cycle E: `Rx_EN`=0 and `locked_out`=1 at E+1.
- Reset is synchronous. When `reset`=0 at a clock edge, all reset values hold from the next cycle, including mid-RECONFIG and mid-push.

## Test plan
- Reset, then `cfg_wr` with baud=3 and enable=1; drive `Rx_VALID` high for 50 cycles with `Rx_DATA`=0xA5 → exactly one entry; `rd_data`=0xA5, `fifo_count`=1; `rd_req` → `rd_valid`=0.
- With `FIFO_DEPTH`=4, push 5 good bytes 0x01..0x05 with no pops → `fifo_count`=4, `overrun`=1, reads return 0x01..0x04. When full, push and pop in the same cycle → count stays 4, order preserved.
- In RUN at baud 3, `cfg_wr` with baud=5 → `Rx_EN` low for exactly 16 cycles, then `baud_select`=5 and `Rx_EN`=1. A `Rx_VALID` edge during the guard is not pushed.
- Three `Rx_PERROR` edges with no good frame between → `perr_count`=3, `locked_out`=1, `Rx_EN`=0. `clear` → DISABLED, counters 0. `cfg_wr` with enable=1 → RUN.
- Errored, good, errored, errored → no lockout, `ferr_count`=3. 260 `Rx_FERROR` edges with `ERR_LIMIT` set large → `ferr_count` saturates at 255.
- Assert `reset`=0 mid-RECONFIG with 2 FIFO entries → all outputs at their reset values next cycle, FIFO empty.
